// File: rtl/ts_fifo_read_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ts_pkg
// Shared constants for the TS FIFO read-side sequencer: default packet
// length, the MPEG-TS sync byte and the controller state encoding.
// States are plain localparam constants so older tools and netlists that
// expect a fixed 3-bit encoding keep working.
// ---------------------------------------------------------------------------
package ts_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CHK  = 3'd1;
  localparam state_t ST_HUNT = 3'd2;
  localparam state_t ST_PKT  = 3'd3;
  localparam state_t ST_GAP  = 3'd4;

endpackage

// File: rtl/ts_fifo_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// ts_fifo_read_ctrl_if
// Bundles the FIFO read port and the downstream byte stream.
//   rempty/ren/rdata            : async FIFO read side
//   m_valid/m_ready/m_data/
//   m_sop/m_eop                 : framed output stream
// master = the read controller, slave = FIFO + downstream sink.
// ---------------------------------------------------------------------------
interface ts_fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  rempty;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    input  rempty, rdata, m_ready,
    output ren, m_valid, m_data, m_sop, m_eop
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  ren, m_valid, m_data, m_sop, m_eop
  );

endinterface

// File: rtl/ts_fifo_read_ctrl_out_buf.sv
// ---------------------------------------------------------------------------
// ts_out_buf
// Two-entry output skid buffer holding {sop, eop, data}.
// Ports:
//   rclk, rrst         : clock, async active-high reset
//   push, push_sop,
//   push_eop, push_data: write one entry (caller guarantees space)
//   ready              : downstream accept
//   pop                : valid && ready, reported back to the controller
//   occupancy          : entries held (0..2)
//   valid, data,
//   sop, eop           : head entry, stable until popped
// ---------------------------------------------------------------------------
module ts_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  push,
  input  logic                  push_sop,
  input  logic                  push_eop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic                  pop,
  output logic [1:0]            occupancy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  sop,
  output logic                  eop
);

  logic [DATA_WIDTH+1:0] mem [2];
  logic                  wptr;
  logic                  rptr;

  assign valid = (occupancy != 2'd0);
  assign pop   = valid && ready;
  assign {sop, eop, data} = mem[rptr];

  // Entries are cleared on reset so the stream outputs read as zero.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= {push_sop, push_eop, push_data};
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ts_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// ts_fifo_read_ctrl
// Read-side sequencer for the TS async FIFO. Aligns on the sync byte,
// forwards 188-byte packets with SOP/EOP and paces packets with a
// programmable idle gap.
// Ports:
//   rclk, rrst      : read clock, async active-high reset
//   enable          : run request, sampled only at packet boundaries
//   gap_cycles      : idle cycles enforced after each packet
//   bus (master)    : FIFO read port + output stream
//   locked          : sync acquired
//   pkt_count       : packets fully fetched (wraps)
//   sync_err_count  : sync checks failed while locked (saturates)
// ---------------------------------------------------------------------------
module ts_fifo_read_ctrl
  import ts_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = TS_PKT_LEN,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int                    GAP_W      = 16,
  parameter int                    CNT_W      = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic [GAP_W-1:0] gap_cycles,
  ts_fifo_read_ctrl_if.master bus,
  output logic             locked,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] sync_err_count
);

  localparam int                FCNT_W = $clog2(PKT_LEN + 1);
  localparam logic [FCNT_W-1:0] LEN_C  = FCNT_W'(PKT_LEN);
  localparam logic [FCNT_W-1:0] LAST_C = FCNT_W'(PKT_LEN - 1);

  state_t            state;
  logic              inflight;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] acnt;
  logic [GAP_W-1:0]  gcnt;
  logic              fetch;
  logic              push;
  logic              push_sop;
  logic              push_eop;
  logic              pop;
  logic [1:0]        occupancy;
  logic              space_ok;
  logic              is_sync;
  state_t            boundary_state;

  // A byte fetched last cycle is on rdata now.
  assign is_sync        = (bus.rdata == SYNC_BYTE);
  assign boundary_state = enable ? ST_CHK : ST_IDLE;

  // Counts bytes already held plus the one in flight, minus the one leaving
  // this cycle, so a new fetch can never find the buffer full on arrival.
  assign space_ok = ({1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;

  // CHK/HUNT fetch one byte at a time; PKT streams while space allows.
  always_comb begin
    fetch = 1'b0;
    case (state)
      ST_CHK, ST_HUNT: fetch = !inflight && space_ok;
      ST_PKT:          fetch = (fcnt < LEN_C) && space_ok;
      default:         fetch = 1'b0;
    endcase
    fetch = fetch && !bus.rempty;
  end

  assign bus.ren = fetch;

  // Arriving bytes are pushed when they are the sync byte of a new packet
  // or any byte inside a packet; acnt tracks the arrival index for EOP.
  always_comb begin
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    if (inflight) begin
      case (state)
        ST_CHK, ST_HUNT: begin
          push     = is_sync;
          push_sop = is_sync;
        end
        ST_PKT: begin
          push     = 1'b1;
          push_eop = (acnt == LAST_C);
        end
        default: push = 1'b0;
      endcase
    end
  end

  ts_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (push),
    .push_sop  (push_sop),
    .push_eop  (push_eop),
    .push_data (bus.rdata),
    .ready     (bus.m_ready),
    .pop       (pop),
    .occupancy (occupancy),
    .valid     (bus.m_valid),
    .data      (bus.m_data),
    .sop       (bus.m_sop),
    .eop       (bus.m_eop)
  );

  // Main sequencer. The gap value is latched with the final fetch so later
  // changes to gap_cycles only affect the following packet; the gap itself
  // is timed from EOP arrival so FIFO stalls never shorten it.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state          <= ST_IDLE;
      inflight       <= 1'b0;
      fcnt           <= '0;
      acnt           <= '0;
      gcnt           <= '0;
      locked         <= 1'b0;
      pkt_count      <= '0;
      sync_err_count <= '0;
    end else begin
      inflight <= fetch;

      if (fetch && (state == ST_PKT)) begin
        fcnt <= fcnt + FCNT_W'(1);
        if (fcnt == LAST_C) begin
          pkt_count <= pkt_count + CNT_W'(1);
          gcnt      <= gap_cycles;
        end
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_CHK;
          end
        end
        ST_CHK, ST_HUNT: begin
          if (inflight) begin
            if (is_sync) begin
              locked <= 1'b1;
              fcnt   <= FCNT_W'(1);
              acnt   <= FCNT_W'(1);
              state  <= ST_PKT;
            end else begin
              if (locked && (sync_err_count != '1)) begin
                sync_err_count <= sync_err_count + CNT_W'(1);
              end
              locked <= 1'b0;
              state  <= ST_HUNT;
            end
          end
        end
        ST_PKT: begin
          if (inflight) begin
            acnt <= acnt + FCNT_W'(1);
            if (acnt == LAST_C) begin
              state <= (gcnt == '0) ? boundary_state : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gcnt <= gcnt - GAP_W'(1);
          if (gcnt <= GAP_W'(1)) begin
            state <= boundary_state;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
